// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared CNN types and constants. Holds the coefficient type,
//            the filter-buffer FSM state encoding, default geometry and
//            helpers for row-major KxK windows ([0][0] in the LSBs).
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_DEF_DATA_W      = 16;
    localparam int c_DEF_K           = 5;
    localparam int c_DEF_NUM_FILTERS = 1920;
    localparam int c_DEF_WIN_W       = c_DEF_K * c_DEF_K * c_DEF_DATA_W;

    typedef logic signed [c_DEF_DATA_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } filt_state_e;

    typedef coef_t win_arr_t [c_DEF_K][c_DEF_K];

    // Flatten a [row][col] window into the row-major bus layout.
    function automatic logic [c_DEF_WIN_W-1:0] pack_window(input win_arr_t w);
        logic [c_DEF_WIN_W-1:0] v;
        v = '0;
        for (int r = 0; r < c_DEF_K; r++) begin
            for (int c = 0; c < c_DEF_K; c++) begin
                v[(r*c_DEF_K + c)*c_DEF_DATA_W +: c_DEF_DATA_W] = w[r][c];
            end
        end
        return v;
    endfunction

    // Pick one coefficient out of a row-major window bus.
    function automatic coef_t get_coef(input logic [c_DEF_WIN_W-1:0] v,
                                       input int r, input int c);
        return coef_t'(v[(r*c_DEF_K + c)*c_DEF_DATA_W +: c_DEF_DATA_W]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_row_mem.sv
`default_nettype none
// ============================================================================
// Module   : filter_row_mem
// Purpose  : Coefficient store built as K row banks. One row of one slot is
//            written per cycle; all K rows of one slot are read together
//            with a registered (1-cycle) read. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module filter_row_mem
    import cnn_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int K      = c_DEF_K,
    parameter int DEPTH  = c_DEF_NUM_FILTERS,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int ROW_W  = (K > 1) ? $clog2(K) : 1
)(
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ROW_W-1:0]      i_wr_row,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [K*DATA_W-1:0]   i_wr_data,
    input  logic                  i_rd_en,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [K*K*DATA_W-1:0] o_rd_data
);

    for (genvar g = 0; g < K; g++) begin : g_row
        logic [K*DATA_W-1:0] r_mem [DEPTH];
        logic [K*DATA_W-1:0] r_q;

        // Bank g holds row g of every slot; the read register only moves on a read.
        always_ff @(posedge clk) begin
            if (i_wr_en && (i_wr_row == ROW_W'(g))) begin
                r_mem[i_wr_idx] <= i_wr_data;
            end
            if (i_rd_en) begin
                r_q <= r_mem[i_rd_idx];
            end
        end

        assign o_rd_data[g*K*DATA_W +: K*DATA_W] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/filter_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : filter_bank_buffer
// Purpose  : Indexed store of KxK convolution filters. Slots are loaded
//            row-serially over a valid/ready stream and read back as a full
//            window one cycle after the request. A valid bitmap and counter
//            track which slots hold complete filters.
// Config   : FILTER_BUF_FWD_EN - when defined, a read of the slot finishing
//            its load (DONE cycle) already reports a hit with the new data.
// Revision : 1.0 - initial release
// ============================================================================
module filter_bank_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W      = c_DEF_DATA_W,
    parameter int K           = c_DEF_K,
    parameter int NUM_FILTERS = c_DEF_NUM_FILTERS,
    parameter int IDX_W       = $clog2(NUM_FILTERS)
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               load_req,
    input  logic [IDX_W-1:0]                   load_idx,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [K*DATA_W-1:0]                wr_row,
    output logic                               load_done,
    output logic                               load_err,
    input  logic                               rd_en,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic                               rd_valid,
    output logic                               rd_hit,
    output logic [K*K*DATA_W-1:0]              rd_filter,
    output logic [$clog2(NUM_FILTERS+1)-1:0]   loaded_count
);

    localparam int ROW_W = (K > 1) ? $clog2(K) : 1;
    localparam int CNT_W = $clog2(NUM_FILTERS + 1);
    localparam logic [IDX_W:0]     c_NUM_EXT = (IDX_W+1)'(NUM_FILTERS);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = CNT_W'(NUM_FILTERS);
    localparam logic [ROW_W-1:0]   c_LAST_ROW = ROW_W'(K - 1);

    filt_state_e              r_state;
    logic [NUM_FILTERS-1:0]   r_valid;
    logic [IDX_W-1:0]         r_idx;
    logic [ROW_W-1:0]         r_row_cnt;
    logic [CNT_W-1:0]         r_loaded_count;
    logic                     r_wr_ready;
    logic                     r_load_done;
    logic                     r_load_err;
    logic                     r_rd_valid;
    logic                     r_rd_hit;

    logic                     w_load_in_range;
    logic                     w_rd_in_range;
    logic                     w_beat;
    logic                     w_mem_wr;
    logic                     w_fwd_hit;
    logic                     w_rd_hit;
    logic [K*K*DATA_W-1:0]    w_mem_q;

    assign w_load_in_range = {1'b0, load_idx} < c_NUM_EXT;
    assign w_rd_in_range   = {1'b0, rd_idx} < c_NUM_EXT;
    assign w_beat          = (r_state == LOAD) && wr_valid;
    // A clear or reset landing on a beat discards it; the slot is invalid anyway.
    assign w_mem_wr        = w_beat && !clear && !rst;

`ifdef FILTER_BUF_FWD_EN
    // The last row is already in memory during DONE, so only the valid bit needs forwarding.
    assign w_fwd_hit = (r_state == DONE) && (r_idx == rd_idx) && !clear;
`else
    assign w_fwd_hit = 1'b0;
`endif

    assign w_rd_hit = w_rd_in_range && (r_valid[rd_idx] || w_fwd_hit);

    filter_row_mem #(
        .DATA_W (DATA_W),
        .K      (K),
        .DEPTH  (NUM_FILTERS),
        .IDX_W  (IDX_W),
        .ROW_W  (ROW_W)
    ) u_row_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_wr),
        .i_wr_row  (r_row_cnt),
        .i_wr_idx  (r_idx),
        .i_wr_data (wr_row),
        .i_rd_en   (rd_en && w_rd_in_range),
        .i_rd_idx  (rd_idx),
        .o_rd_data (w_mem_q)
    );

    // Load sequencer: owns the valid bitmap, the slot counter and the load handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_valid        <= '0;
            r_idx          <= '0;
            r_row_cnt      <= '0;
            r_loaded_count <= '0;
            r_wr_ready     <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            if (clear) begin
                r_state        <= IDLE;
                r_valid        <= '0;
                r_loaded_count <= '0;
                r_wr_ready     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load_req) begin
                            if (w_load_in_range) begin
                                r_state    <= LOAD;
                                r_idx      <= load_idx;
                                r_row_cnt  <= '0;
                                r_wr_ready <= 1'b1;
                                // A reload hides the old filter for the whole load.
                                if (r_valid[load_idx]) begin
                                    r_valid[load_idx] <= 1'b0;
                                    r_loaded_count    <= r_loaded_count - 1'b1;
                                end
                            end else begin
                                r_load_err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (wr_valid) begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                            if (r_row_cnt == c_LAST_ROW) begin
                                r_state     <= DONE;
                                r_wr_ready  <= 1'b0;
                                r_load_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_state        <= IDLE;
                        r_valid[r_idx] <= 1'b1;
                        if (r_loaded_count < c_CNT_MAX) begin
                            r_loaded_count <= r_loaded_count + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Read response: hit is captured with the request; both hit and data hold between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_hit <= w_rd_hit;
            end
        end
    end

    // Slot count can never exceed the number of slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_loaded_count <= c_CNT_MAX);
        end
    end

    assign wr_ready     = r_wr_ready;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign rd_valid     = r_rd_valid;
    assign rd_hit       = r_rd_hit;
    assign rd_filter    = r_rd_hit ? w_mem_q : '0;
    assign loaded_count = r_loaded_count;

endmodule
`default_nettype wire
